// File: rtl/alu_unit_pkg.sv
// Shared core constants (widths, opcode encodings) and the CDB result record used by alu_unit.
package alu_unit_pkg;

    localparam int IDWidth       = 32;
    localparam int ROBWidth      = 4;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;

    localparam logic [InstTypeWidth-1:0] NOP   = 6'd0;
    localparam logic [InstTypeWidth-1:0] ADD   = 6'd1;
    localparam logic [InstTypeWidth-1:0] SUB   = 6'd2;
    localparam logic [InstTypeWidth-1:0] SLL   = 6'd3;
    localparam logic [InstTypeWidth-1:0] SLT   = 6'd4;
    localparam logic [InstTypeWidth-1:0] SLTU  = 6'd5;
    localparam logic [InstTypeWidth-1:0] XOR   = 6'd6;
    localparam logic [InstTypeWidth-1:0] SRL   = 6'd7;
    localparam logic [InstTypeWidth-1:0] SRA   = 6'd8;
    localparam logic [InstTypeWidth-1:0] OR    = 6'd9;
    localparam logic [InstTypeWidth-1:0] AND   = 6'd10;
    localparam logic [InstTypeWidth-1:0] ADDI  = 6'd11;
    localparam logic [InstTypeWidth-1:0] SLTI  = 6'd12;
    localparam logic [InstTypeWidth-1:0] SLTIU = 6'd13;
    localparam logic [InstTypeWidth-1:0] XORI  = 6'd14;
    localparam logic [InstTypeWidth-1:0] ORI   = 6'd15;
    localparam logic [InstTypeWidth-1:0] ANDI  = 6'd16;
    localparam logic [InstTypeWidth-1:0] SLLI  = 6'd17;
    localparam logic [InstTypeWidth-1:0] SRLI  = 6'd18;
    localparam logic [InstTypeWidth-1:0] SRAI  = 6'd19;
    localparam logic [InstTypeWidth-1:0] LUI   = 6'd20;
    localparam logic [InstTypeWidth-1:0] AUIPC = 6'd21;
    localparam logic [InstTypeWidth-1:0] JAL   = 6'd22;
    localparam logic [InstTypeWidth-1:0] JALR  = 6'd23;
    localparam logic [InstTypeWidth-1:0] BEQ   = 6'd24;
    localparam logic [InstTypeWidth-1:0] BNE   = 6'd25;
    localparam logic [InstTypeWidth-1:0] BLT   = 6'd26;
    localparam logic [InstTypeWidth-1:0] BGE   = 6'd27;
    localparam logic [InstTypeWidth-1:0] BLTU  = 6'd28;
    localparam logic [InstTypeWidth-1:0] BGEU  = 6'd29;

    typedef struct packed {
        logic [ROBWidth-1:0]     b;
        logic [IDWidth-1:0]      result;
        logic [AddressWidth-1:0] target;
        logic                    taken;
    } cdb_entry_t;

    function automatic logic is_branch(input logic [InstTypeWidth-1:0] op);
        return (op >= BEQ) && (op <= BGEU);
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU compute stage and the CDB; en freezes it, flush empties it.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = en & ~flush & pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_push = en & ~flush & push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en && flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_unit.sv
// Two-stage integer ALU/branch unit feeding the CDB through a result FIFO.
// Optional ALU_STALL_COUNT_EN adds a saturating count of cycles lost waiting for CDB grant.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [IDWidth-1:0]       rs_alu_a_in,
    input  logic [IDWidth-1:0]       rs_alu_vj_in,
    input  logic [IDWidth-1:0]       rs_alu_vk_in,
    input  logic [ROBWidth-1:0]      rs_alu_dest_in,
    input  logic [AddressWidth-1:0]  rs_alu_pc_in,
    input  logic [InstTypeWidth-1:0] rs_alu_opcode_in,
    output logic                     alu_rs_full_out,
    input  logic                     rob_alu_rst_in,
    output logic                     alu_cdb_en_out,
    input  logic                     cdb_alu_grant_in,
    output logic [ROBWidth-1:0]      alu_cdb_b_out,
    output logic [IDWidth-1:0]       alu_cdb_result_out,
    output logic [AddressWidth-1:0]  alu_cdb_target_out,
    output logic                     alu_cdb_taken_out
`ifdef ALU_STALL_COUNT_EN
    ,
    output logic [31:0]              alu_stall_cnt_out
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     flush, issue;
    logic                     ex_valid;
    logic [InstTypeWidth-1:0] ex_op;
    logic [IDWidth-1:0]       ex_a, ex_vj, ex_vk;
    logic [ROBWidth-1:0]      ex_dest;
    logic [AddressWidth-1:0]  ex_pc, pc_next;
    logic [IDWidth-1:0]       res;
    logic [AddressWidth-1:0]  tgt;
    logic                     tkn;
    cdb_entry_t               push_entry, head;
    logic [CW-1:0]            fifo_count;
    logic [CW:0]              occupancy;
    logic                     fifo_empty, fifo_full;

    assign flush = rob_alu_rst_in & rdy_in;
    assign issue = rdy_in & ~flush & (rs_alu_opcode_in != NOP) & ~alu_rs_full_out;

    // The in-flight ex op is counted so the RS sees full one cycle early.
    assign occupancy       = {1'b0, fifo_count} + {{CW{1'b0}}, ex_valid};
    assign alu_rs_full_out = occupancy >= (CW+1)'(DEPTH - 1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ex_valid <= 1'b0;
            ex_op    <= NOP;
            ex_a     <= '0;
            ex_vj    <= '0;
            ex_vk    <= '0;
            ex_dest  <= '0;
            ex_pc    <= '0;
        end else if (rdy_in) begin
            ex_valid <= issue;
            if (issue) begin
                ex_op   <= rs_alu_opcode_in;
                ex_a    <= rs_alu_a_in;
                ex_vj   <= rs_alu_vj_in;
                ex_vk   <= rs_alu_vk_in;
                ex_dest <= rs_alu_dest_in;
                ex_pc   <= rs_alu_pc_in;
            end
        end
    end

    assign pc_next = ex_pc + AddressWidth'(4);

    always_comb begin
        res = '0;
        tgt = pc_next;
        tkn = 1'b0;
        case (ex_op)
            ADD:   res = ex_vj + ex_vk;
            SUB:   res = ex_vj - ex_vk;
            SLL:   res = ex_vj << ex_vk[4:0];
            SLT:   res = IDWidth'($signed(ex_vj) < $signed(ex_vk));
            SLTU:  res = IDWidth'(ex_vj < ex_vk);
            XOR:   res = ex_vj ^ ex_vk;
            SRL:   res = ex_vj >> ex_vk[4:0];
            SRA:   res = $signed(ex_vj) >>> ex_vk[4:0];
            OR:    res = ex_vj | ex_vk;
            AND:   res = ex_vj & ex_vk;
            ADDI:  res = ex_vj + ex_a;
            SLTI:  res = IDWidth'($signed(ex_vj) < $signed(ex_a));
            SLTIU: res = IDWidth'(ex_vj < ex_a);
            XORI:  res = ex_vj ^ ex_a;
            ORI:   res = ex_vj | ex_a;
            ANDI:  res = ex_vj & ex_a;
            SLLI:  res = ex_vj << ex_a[4:0];
            SRLI:  res = ex_vj >> ex_a[4:0];
            SRAI:  res = $signed(ex_vj) >>> ex_a[4:0];
            LUI:   res = ex_a;
            AUIPC: res = IDWidth'(ex_pc + AddressWidth'(ex_a));
            JAL: begin
                res = IDWidth'(pc_next);
                tgt = ex_pc + AddressWidth'(ex_a);
                tkn = 1'b1;
            end
            JALR: begin
                res = IDWidth'(pc_next);
                tgt = AddressWidth'(ex_vj + ex_a) & ~AddressWidth'(1);
                tkn = 1'b1;
            end
            BEQ:   tkn = (ex_vj == ex_vk);
            BNE:   tkn = (ex_vj != ex_vk);
            BLT:   tkn = $signed(ex_vj) < $signed(ex_vk);
            BGE:   tkn = $signed(ex_vj) >= $signed(ex_vk);
            BLTU:  tkn = ex_vj < ex_vk;
            BGEU:  tkn = ex_vj >= ex_vk;
            default: ;
        endcase
        if (is_branch(ex_op) && tkn) tgt = ex_pc + AddressWidth'(ex_a);
    end

    assign push_entry = '{b: ex_dest, result: res, target: tgt, taken: tkn};

    alu_result_fifo #(
        .WIDTH ($bits(cdb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (rdy_in),
        .flush (rob_alu_rst_in),
        .push  (ex_valid),
        .pop   (cdb_alu_grant_in),
        .din   (push_entry),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign alu_cdb_en_out     = ~fifo_empty;
    assign alu_cdb_b_out      = head.b;
    assign alu_cdb_result_out = head.result;
    assign alu_cdb_target_out = head.target;
    assign alu_cdb_taken_out  = head.taken;

`ifdef ALU_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            stall_cnt <= '0;
        else if (rdy_in && alu_cdb_en_out && !cdb_alu_grant_in && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign alu_stall_cnt_out = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic against a queue model.
module tb_alu_unit;
    import alu_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int NOPS  = 29;

    logic                     clk_in = 1'b0;
    logic                     rst_in = 1'b1;
    logic                     rdy_in = 1'b1;
    logic [IDWidth-1:0]       rs_alu_a_in = '0, rs_alu_vj_in = '0, rs_alu_vk_in = '0;
    logic [ROBWidth-1:0]      rs_alu_dest_in = '0;
    logic [AddressWidth-1:0]  rs_alu_pc_in = '0;
    logic [InstTypeWidth-1:0] rs_alu_opcode_in = NOP;
    logic                     alu_rs_full_out;
    logic                     rob_alu_rst_in = 1'b0;
    logic                     alu_cdb_en_out;
    logic                     cdb_alu_grant_in = 1'b0;
    logic [ROBWidth-1:0]      alu_cdb_b_out;
    logic [IDWidth-1:0]       alu_cdb_result_out;
    logic [AddressWidth-1:0]  alu_cdb_target_out;
    logic                     alu_cdb_taken_out;
`ifdef ALU_STALL_COUNT_EN
    logic [31:0]              alu_stall_cnt_out;
    logic [31:0]              cnt0;
`endif

    int tests = 0;
    int fails = 0;
    cdb_entry_t q[$];
    cdb_entry_t ea, eb, ec;
    logic [InstTypeWidth-1:0] ops [NOPS];

    alu_unit #(.DEPTH(DEPTH)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .rs_alu_a_in        (rs_alu_a_in),
        .rs_alu_vj_in       (rs_alu_vj_in),
        .rs_alu_vk_in       (rs_alu_vk_in),
        .rs_alu_dest_in     (rs_alu_dest_in),
        .rs_alu_pc_in       (rs_alu_pc_in),
        .rs_alu_opcode_in   (rs_alu_opcode_in),
        .alu_rs_full_out    (alu_rs_full_out),
        .rob_alu_rst_in     (rob_alu_rst_in),
        .alu_cdb_en_out     (alu_cdb_en_out),
        .cdb_alu_grant_in   (cdb_alu_grant_in),
        .alu_cdb_b_out      (alu_cdb_b_out),
        .alu_cdb_result_out (alu_cdb_result_out),
        .alu_cdb_target_out (alu_cdb_target_out),
        .alu_cdb_taken_out  (alu_cdb_taken_out)
`ifdef ALU_STALL_COUNT_EN
        ,
        .alu_stall_cnt_out  (alu_stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input cdb_entry_t e);
        check(tag, {alu_cdb_en_out, alu_cdb_b_out, alu_cdb_result_out, alu_cdb_target_out, alu_cdb_taken_out},
                   {1'b1, e.b, e.result, e.target, e.taken});
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [InstTypeWidth-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] a, input logic [31:0] pc, input logic [ROBWidth-1:0] dest);
        rs_alu_opcode_in = op;
        rs_alu_vj_in     = vj;
        rs_alu_vk_in     = vk;
        rs_alu_a_in      = a;
        rs_alu_pc_in     = pc;
        rs_alu_dest_in   = dest;
    endtask

    // Issue one op and wait until its result sits at the CDB head.
    task automatic issue_and_wait(input logic [InstTypeWidth-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                  input logic [31:0] a, input logic [31:0] pc, input logic [ROBWidth-1:0] dest);
        drive(op, vj, vk, a, pc, dest);
        step();
        rs_alu_opcode_in = NOP;
        step();
    endtask

    function automatic logic [31:0] sra(input logic [31:0] x, input int s);
        logic [31:0] v = x;
        for (int i = 0; i < s; i++) v = {v[31], v[31:1]};
        return v;
    endfunction

    // Architectural reference: what the op means, computed with plain arithmetic.
    function automatic cdb_entry_t ref_model(input logic [InstTypeWidth-1:0] op, input logic [31:0] vj,
                                             input logic [31:0] vk, input logic [31:0] a,
                                             input logic [31:0] pc, input logic [ROBWidth-1:0] dest);
        cdb_entry_t e;
        logic [31:0] pc4 = pc + 32'd4;
        logic br = 1'b0;
        int sk = int'(vk % 32);
        int sa = int'(a % 32);
        e = '{b: dest, result: 32'd0, target: pc4, taken: 1'b0};
        case (op)
            ADD:   e.result = vj + vk;
            SUB:   e.result = vj - vk;
            SLL:   e.result = vj * (32'd1 << sk);
            SLT:   e.result = (int'(vj) < int'(vk)) ? 32'd1 : 32'd0;
            SLTU:  e.result = (longint'(vj) < longint'(vk)) ? 32'd1 : 32'd0;
            XOR:   e.result = vj ^ vk;
            SRL:   e.result = vj / (32'd1 << sk);
            SRA:   e.result = sra(vj, sk);
            OR:    e.result = vj | vk;
            AND:   e.result = vj & vk;
            ADDI:  e.result = vj + a;
            SLTI:  e.result = (int'(vj) < int'(a)) ? 32'd1 : 32'd0;
            SLTIU: e.result = (longint'(vj) < longint'(a)) ? 32'd1 : 32'd0;
            XORI:  e.result = vj ^ a;
            ORI:   e.result = vj | a;
            ANDI:  e.result = vj & a;
            SLLI:  e.result = vj * (32'd1 << sa);
            SRLI:  e.result = vj / (32'd1 << sa);
            SRAI:  e.result = sra(vj, sa);
            LUI:   e.result = a;
            AUIPC: e.result = pc + a;
            JAL:   begin e.result = pc4; e.target = pc + a; e.taken = 1'b1; end
            JALR:  begin e.result = pc4; e.target = (vj + a) & 32'hFFFF_FFFE; e.taken = 1'b1; end
            BEQ:   br = (vj == vk);
            BNE:   br = (vj != vk);
            BLT:   br = int'(vj) < int'(vk);
            BGE:   br = int'(vj) >= int'(vk);
            BLTU:  br = longint'(vj) < longint'(vk);
            BGEU:  br = longint'(vj) >= longint'(vk);
            default: ;
        endcase
        if (op >= BEQ && op <= BGEU) begin
            e.taken  = br;
            e.target = br ? pc + a : pc4;
        end
        return e;
    endfunction

    initial begin
        for (int i = 0; i < NOPS; i++) ops[i] = InstTypeWidth'(i + 1);

        // Reset state
        #12;
        check("reset_en", alu_cdb_en_out, 0);
        check("reset_b", alu_cdb_b_out, 0);
        check("reset_result", alu_cdb_result_out, 0);
        check("reset_target", alu_cdb_target_out, 0);
        check("reset_taken", alu_cdb_taken_out, 0);
        check("reset_full", alu_rs_full_out, 0);
        rst_in = 1'b0;
        step();

        // ADD latency and pop with grant held
        cdb_alu_grant_in = 1'b1;
        drive(ADD, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
        step();
        rs_alu_opcode_in = NOP;
        check("add_not_yet", alu_cdb_en_out, 0);
        step();
        check_head("add_head", '{b: 4'd3, result: 32'd12, target: 32'h204, taken: 1'b0});
        step();
        check("add_popped", alu_cdb_en_out, 0);

        // Branch / jump / shift directed cases
        issue_and_wait(BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd4);
        check_head("blt", '{b: 4'd4, result: 32'd0, target: 32'h120, taken: 1'b1});
        issue_and_wait(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5);
        check_head("bltu", '{b: 4'd5, result: 32'd0, target: 32'h104, taken: 1'b0});
        issue_and_wait(JALR, 32'h1001, 32'd0, 32'd4, 32'h40, 4'd6);
        check_head("jalr", '{b: 4'd6, result: 32'h44, target: 32'h1004, taken: 1'b1});
        issue_and_wait(SRAI, 32'h8000_0000, 32'd0, 32'd33, 32'h80, 4'd7);
        check_head("srai", '{b: 4'd7, result: 32'hC000_0000, target: 32'h84, taken: 1'b0});
        step();
        check("directed_drained", alu_cdb_en_out, 0);

        // Back-pressure: grant low, three back-to-back issues
        cdb_alu_grant_in = 1'b0;
        ea = '{b: 4'd1, result: 32'd3, target: 32'h14, taken: 1'b0};
        eb = '{b: 4'd2, result: 32'hF0, target: 32'h18, taken: 1'b0};
        ec = '{b: 4'd3, result: 32'h1234_5000, target: 32'h1C, taken: 1'b0};
        drive(ADDI, 32'd1, 32'd0, 32'd2, 32'h10, 4'd1); step();
        check("bp_full_1", alu_rs_full_out, 0);
        drive(OR, 32'hF0, 32'h00, 32'd0, 32'h14, 4'd2); step();
        check("bp_full_2", alu_rs_full_out, 0);
        drive(LUI, 32'd0, 32'd0, 32'h1234_5000, 32'h18, 4'd3); step();
        rs_alu_opcode_in = NOP;
        check("bp_full_3", alu_rs_full_out, 1);
        check_head("bp_head_a", ea);
        step();
        step();
        check_head("bp_head_stable", ea);
        check("bp_full_hold", alu_rs_full_out, 1);
        cdb_alu_grant_in = 1'b1;
        step(); check_head("bp_pop_b", eb);
        step(); check_head("bp_pop_c", ec);
        step();
        check("bp_empty", alu_cdb_en_out, 0);
        check("bp_full_clear", alu_rs_full_out, 0);

        // Flush with two entries buffered and a concurrent issue
        cdb_alu_grant_in = 1'b0;
        drive(ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1); step();
        drive(ADD, 32'd2, 32'd2, 32'd0, 32'h4, 4'd2); step();
        rs_alu_opcode_in = NOP;
        step();
        check("flush_pre_en", alu_cdb_en_out, 1);
        rob_alu_rst_in = 1'b1;
        cdb_alu_grant_in = 1'b1;
        drive(ADD, 32'd3, 32'd3, 32'd0, 32'h8, 4'd3);
        step();
        rob_alu_rst_in = 1'b0;
        rs_alu_opcode_in = NOP;
        check("flush_en", alu_cdb_en_out, 0);
        check("flush_full", alu_rs_full_out, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_no_result", alu_cdb_en_out, 0);
        end

        // rdy_in freeze with a pending result
        cdb_alu_grant_in = 1'b0;
        ea = ref_model(XORI, 32'hAAAA_5555, 32'd0, 32'hFFFF_0000, 32'h300, 4'd9);
        issue_and_wait(XORI, 32'hAAAA_5555, 32'd0, 32'hFFFF_0000, 32'h300, 4'd9);
`ifdef ALU_STALL_COUNT_EN
        cnt0 = alu_stall_cnt_out;
`endif
        step();
        step();
        rdy_in = 1'b0;
        cdb_alu_grant_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_head("rdy_hold", ea);
        end
`ifdef ALU_STALL_COUNT_EN
        check("stall_cnt_frozen", alu_stall_cnt_out, cnt0 + 32'd2);
`endif
        rdy_in = 1'b1;
        step();
        check("rdy_pop", alu_cdb_en_out, 0);
`ifdef ALU_STALL_COUNT_EN
        check("stall_cnt_total", alu_stall_cnt_out, cnt0 + 32'd2);
`endif

        // Asynchronous reset mid-operation
        cdb_alu_grant_in = 1'b0;
        issue_and_wait(SUB, 32'd9, 32'd4, 32'd0, 32'h500, 4'd8);
        check("areset_pre", alu_cdb_en_out, 1);
        #2 rst_in = 1'b1;
        #1 check("areset_en", alu_cdb_en_out, 0);
        check("areset_b", alu_cdb_b_out, 0);
        #1 rst_in = 1'b0;
        step();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [InstTypeWidth-1:0] op;
            logic [31:0] vj, vk, a, pc;
            logic [ROBWidth-1:0] dest;
            rdy_in = ($urandom_range(0, 7) != 0);
            cdb_alu_grant_in = ($urandom_range(0, 2) != 0);
            if (alu_cdb_en_out && cdb_alu_grant_in && rdy_in) begin
                if (q.size() == 0) check("rand_spurious", alu_cdb_en_out, 0);
                else check_head("rand_head", q.pop_front());
            end
            if (!alu_rs_full_out && $urandom_range(0, 3) != 0) begin
                op   = ops[$urandom_range(0, NOPS - 1)];
                vj   = ($urandom_range(0, 3) == 0) ? vk : $urandom;
                vk   = $urandom;
                if ($urandom_range(0, 3) == 0) vj = vk;
                a    = $urandom;
                pc   = {$urandom, 2'b00} & 32'h0000_FFFC;
                dest = ROBWidth'($urandom_range(1, 15));
                drive(op, vj, vk, a, pc, dest);
                if (rdy_in) q.push_back(ref_model(op, vj, vk, a, pc, dest));
            end else begin
                rs_alu_opcode_in = NOP;
            end
            step();
        end

        // Drain with a bounded cycle budget
        rs_alu_opcode_in = NOP;
        rdy_in = 1'b1;
        cdb_alu_grant_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (alu_cdb_en_out) begin
                if (q.size() == 0) check("drain_spurious", alu_cdb_en_out, 0);
                else check_head("drain_head", q.pop_front());
            end
            step();
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_en_low", alu_cdb_en_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
